// File: rtl/comparator_pkg.sv
// Shared flag layout and legal codes for the ForthSuper comparator.
// Optional output register is enabled with COMPARATOR_REG_EN.
package comparator_pkg;

  localparam int CMP_EQ  = 5;
  localparam int CMP_NEQ = 4;
  localparam int CMP_LT  = 3;
  localparam int CMP_LTE = 2;
  localparam int CMP_GT  = 1;
  localparam int CMP_GTE = 0;

  typedef logic [5:0] cmp_flags_t;

  localparam cmp_flags_t CMP_CODE_EQ = 6'b100101;
  localparam cmp_flags_t CMP_CODE_LT = 6'b011100;
  localparam cmp_flags_t CMP_CODE_GT = 6'b010011;

  // Expand the two raw tree results into the full flag vector.
  function automatic cmp_flags_t cmp_flags(
    input logic eq,
    input logic lt
  );
    cmp_flags_t f;
    logic gt;
    gt = ~eq & ~lt;
    f = '0;
    f[CMP_EQ]  = eq;
    f[CMP_NEQ] = ~eq;
    f[CMP_LT]  = lt;
    f[CMP_LTE] = lt | eq;
    f[CMP_GT]  = gt;
    f[CMP_GTE] = gt | eq;
    return f;
  endfunction

endpackage

// File: rtl/comparator_if.sv
// Operand/flag bundle between a comparator user and the comparator.
// Built with or without COMPARATOR_REG_EN; the signal set is the same.
interface comparator_if
  import comparator_pkg::*;
#(
  parameter int N = 32
);

  logic [N-1:0] a;
  logic [N-1:0] b;
  cmp_flags_t   o;

  modport master (
    output a,
    output b,
    input  o
  );

  modport slave (
    input  a,
    input  b,
    output o
  );

endinterface

// File: rtl/cmp_core.sv
// Raw unsigned eq/lt via a log-depth merge tree, MSB-first per pair.
// Unaffected by COMPARATOR_REG_EN.
module cmp_core #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         lt
);

  localparam int L = (N > 1) ? $clog2(N) : 0;
  localparam int P = 1 << L;

  logic [P-1:0] ap;
  logic [P-1:0] bp;
  logic [P-1:0] e_t;
  logic [P-1:0] l_t;

  // Zero padding to a power of two: padded bits read as equal.
  // Each level folds pair (2i+1 hi, 2i lo) into slot i in place.
  always_comb begin
    ap  = P'(a);
    bp  = P'(b);
    e_t = ~(ap ^ bp);
    l_t = ~ap & bp;
    for (int lv = 0; lv < L; lv++) begin
      for (int i = 0; i < (P >> (lv + 1)); i++) begin
        l_t[i] = l_t[2*i+1] | (e_t[2*i+1] & l_t[2*i]);
        e_t[i] = e_t[2*i+1] & e_t[2*i];
      end
    end
  end

  assign eq = e_t[0];
  assign lt = l_t[0];

endmodule

// File: rtl/comparator.sv
// N-bit unsigned comparator producing {eq,neq,lt,lte,gt,gte}.
// COMPARATOR_REG_EN adds a 1-cycle output register with async clear.
module comparator
  import comparator_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output cmp_flags_t o
);

  logic       eq_raw;
  logic       lt_raw;
  cmp_flags_t o_d;

  cmp_core #(
    .N(N)
  ) u_core (
    .a  (a),
    .b  (b),
    .eq (eq_raw),
    .lt (lt_raw)
  );

  always_comb begin
    o_d = cmp_flags(eq_raw, lt_raw);
  end

`ifdef COMPARATOR_REG_EN
  cmp_flags_t o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
    end else begin
      o_q <= o_d;
    end
  end

  assign o = o_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign o = o_d;
`endif

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator, N=32.
// Also covers the registered build when COMPARATOR_REG_EN is defined.
module tb_comparator;
  import comparator_pkg::*;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cmp_flags_t exp_q[$];

  comparator_if #(.N(N)) bus ();

  comparator #(
    .N(N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.a),
    .b     (bus.b),
    .o     (bus.o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cmp_flags_t model(
    input logic [N-1:0] x,
    input logic [N-1:0] y
  );
    if (x == y) return CMP_CODE_EQ;
    if (x < y) return CMP_CODE_LT;
    return CMP_CODE_GT;
  endfunction

  task automatic chk(
    input string      tag,
    input cmp_flags_t got,
    input cmp_flags_t exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(
    input string        tag,
    input logic [N-1:0] x,
    input logic [N-1:0] y
  );
`ifdef COMPARATOR_REG_EN
    @(negedge clk);
`endif
    bus.a = x;
    bus.b = y;
    exp_q.push_back(model(x, y));
`ifdef COMPARATOR_REG_EN
    @(posedge clk);
`endif
    #1;
    chk(tag, bus.o, exp_q.pop_front());
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    n_tests = 0;
    n_fail  = 0;
    bus.a   = '0;
    bus.b   = '0;
    rst_n   = 1'b0;
`ifdef COMPARATOR_REG_EN
    #2;
    chk("rst_async", bus.o, '0);
    bus.a = 32'd0;
    bus.b = 32'd1;
    exp_q.push_back(model(32'd0, 32'd1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_hold", bus.o, '0);
    @(posedge clk);
    #1;
    chk("first_edge", bus.o, exp_q.pop_front());
`else
    #2;
    rst_n = 1'b1;
`endif
    apply("lt_0_1", 32'd0, 32'd1);
    apply("eq_1_1", 32'd1, 32'd1);
    apply("gt_1_0", 32'd1, 32'd0);
    apply("eq_0_0", 32'd0, 32'd0);
    apply("gt_max_0", 32'hFFFF_FFFF, 32'd0);
    apply("eq_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply("lt_adj", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    apply("gt_adj0", 32'hFFFF_FFFE, 32'd0);
    apply("lt_msb", 32'h7FFF_FFFF, 32'h8000_0000);
    apply("gt_msb", 32'h8000_0000, 32'h7FFF_FFFF);
    apply("lt_lsb", 32'h1234_5678, 32'h1234_5679);
    apply("gt_mid", 32'h0001_0000, 32'h0000_FFFF);
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = $urandom;
      endcase
      apply("rand", ra, rb);
    end
`ifdef COMPARATOR_REG_EN
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", bus.o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_rst", 32'd5, 32'd3);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
